// File: rtl/phase_gen_pkg.sv
// Shared constants and FSM state type for the CORDIC phase stream generators.
// Phase words are 1.2.13 signed fixed point.
package phase_gen_pkg;

  localparam int PHASE_W = 16;
  localparam logic [15:0] PI_POS = 16'h6488;
  localparam logic [15:0] PI_NEG = 16'h9B78;
  localparam logic signed [17:0] TWO_PI = 18'sd51472;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/phase_wrap_add.sv
// Combinational phase advance: add a non-negative step and fold anything past +pi
// back by 2*pi, keeping the result inside [-pi, +pi].
module phase_wrap_add #(
  parameter int            W      = phase_gen_pkg::PHASE_W,
  parameter logic [W-1:0]  PI_POS = phase_gen_pkg::PI_POS
) (
  input  logic [W-1:0] phase,
  input  logic [W-1:0] inc,
  output logic [W-1:0] result,
  output logic         wrapped
);

  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] PI_S     = $signed({2'b00, PI_POS});
  localparam logic signed [SW-1:0] TWO_PI_S = PI_S <<< 1;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] folded;

  // The step is unsigned and never exceeds +pi, so only the upper bound can be crossed.
  always_comb begin
    sum     = $signed({{2{phase[W-1]}}, phase}) + $signed({2'b00, inc});
    folded  = sum - TWO_PI_S;
    wrapped = (sum > PI_S);
    result  = wrapped ? folded[W-1:0] : sum[W-1:0];
  end

endmodule

// File: rtl/phase_axis_gen.sv
// AXI-Stream phase word source for a CORDIC: accumulates a clamped step per accepted
// beat, with stop/drain control, wrap flag and a saturating beat counter.
module phase_axis_gen #(
  parameter int                  PHASE_W = phase_gen_pkg::PHASE_W,
  parameter logic [PHASE_W-1:0]  PI_POS  = phase_gen_pkg::PI_POS
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  phase_clr,
  input  logic [PHASE_W-1:0]    phase_inc,
  input  logic                  inc_load,
  output logic                  m_axis_phase_tvalid,
  input  logic                  m_axis_phase_tready,
  output logic [PHASE_W-1:0]    m_axis_phase_tdata,
  output logic                  wrap_pulse,
  output logic [31:0]           beat_count,
  output phase_gen_pkg::state_t dbg_state
);

  // Handshake: a beat transfers on any rising edge where tvalid and tready are both 1;
  // once tvalid is raised, tvalid and tdata hold unchanged until that transfer happens.

  phase_gen_pkg::state_t state_q, state_d;

  logic               accept;
  logic [PHASE_W-1:0] inc_active_q;
  logic [PHASE_W-1:0] inc_clamped;
  logic [PHASE_W-1:0] inc_eff;
  logic [PHASE_W-1:0] phase_adv;
  logic               wrapped;

  assign accept      = m_axis_phase_tvalid & m_axis_phase_tready;
  assign inc_clamped = (phase_inc > PI_POS) ? PI_POS : phase_inc;
  // A same-cycle load takes effect on the advance it coincides with.
  assign inc_eff     = inc_load ? inc_clamped : inc_active_q;
  assign dbg_state   = state_q;

  phase_wrap_add #(
    .W      (PHASE_W),
    .PI_POS (PI_POS)
  ) u_wrap (
    .phase   (m_axis_phase_tdata),
    .inc     (inc_eff),
    .result  (phase_adv),
    .wrapped (wrapped)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      phase_gen_pkg::ST_IDLE: begin
        if (enable) state_d = phase_gen_pkg::ST_RUN;
      end
      phase_gen_pkg::ST_RUN: begin
        if (!enable) state_d = accept ? phase_gen_pkg::ST_IDLE : phase_gen_pkg::ST_DRAIN;
      end
      phase_gen_pkg::ST_DRAIN: begin
        if (accept) state_d = phase_gen_pkg::ST_IDLE;
      end
      default: state_d = phase_gen_pkg::ST_IDLE;
    endcase
  end

  // tdata doubles as the phase accumulator, so it is retained while idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q             <= phase_gen_pkg::ST_IDLE;
      m_axis_phase_tvalid <= 1'b0;
      m_axis_phase_tdata  <= '0;
      inc_active_q        <= '0;
      wrap_pulse          <= 1'b0;
      beat_count          <= '0;
    end else begin
      state_q             <= state_d;
      m_axis_phase_tvalid <= (state_d != phase_gen_pkg::ST_IDLE);
      wrap_pulse          <= accept & wrapped;
      if (inc_load) inc_active_q <= inc_clamped;
      if (accept) begin
        m_axis_phase_tdata <= phase_adv;
        if (beat_count != 32'hFFFF_FFFF) beat_count <= beat_count + 32'd1;
      end else if (state_q == phase_gen_pkg::ST_IDLE && phase_clr) begin
        m_axis_phase_tdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_phase_axis_gen.sv
// Directed bench for phase_axis_gen: streaming, wrap, backpressure, drain, clamp/bypass
// and asynchronous reset, with hand-computed expected values.
module tb_phase_axis_gen;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic        phase_clr;
  logic [15:0] phase_inc;
  logic        inc_load;
  logic        tvalid;
  logic        tready;
  logic [15:0] tdata;
  logic        wrap_pulse;
  logic [31:0] beat_count;
  phase_gen_pkg::state_t dbg_state;

  int checks = 0;
  int errors = 0;

  phase_axis_gen dut (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .enable              (enable),
    .phase_clr           (phase_clr),
    .phase_inc           (phase_inc),
    .inc_load            (inc_load),
    .m_axis_phase_tvalid (tvalid),
    .m_axis_phase_tready (tready),
    .m_axis_phase_tdata  (tdata),
    .wrap_pulse          (wrap_pulse),
    .beat_count          (beat_count),
    .dbg_state           (dbg_state)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_ph(input string tag, input int exp_i);
    logic [15:0] e;
    e = exp_i[15:0];
    chk(tag, {16'b0, tdata}, {16'b0, e});
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; phase_clr = 1'b0;
    phase_inc = '0; inc_load = 1'b0; tready = 1'b0;
    cyc(); cyc();
    chk("rst_tvalid", {31'b0, tvalid}, 32'd0);
    chk("rst_tdata", {16'b0, tdata}, 32'd0);
    chk("rst_beats", beat_count, 32'd0);
    chk("rst_wrap", {31'b0, wrap_pulse}, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(phase_gen_pkg::ST_IDLE));
    aresetn = 1'b1;
    cyc();

    // Steady stream at step 200
    inc_load = 1'b1; phase_inc = 16'd200;
    cyc();
    inc_load = 1'b0; enable = 1'b1; tready = 1'b1;
    cyc(); chk("stream_v0", {31'b0, tvalid}, 32'd1); chk_ph("stream_0", 0);
    cyc(); chk_ph("stream_200", 200);
    cyc(); chk_ph("stream_400", 400);
    cyc(); chk_ph("stream_600", 600);
    enable = 1'b0;
    cyc();
    chk("stop_tvalid", {31'b0, tvalid}, 32'd0);
    chk_ph("stop_phase", 800);
    chk("stream_beats", beat_count, 32'd4);

    // Backpressure at 400
    phase_clr = 1'b1;
    cyc(); phase_clr = 1'b0; chk_ph("clr_idle", 0);
    enable = 1'b1;
    cyc(); chk_ph("bp_0", 0);
    cyc(); chk_ph("bp_200", 200);
    cyc(); chk_ph("bp_400", 400);
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("bp_hold_v", {31'b0, tvalid}, 32'd1);
      chk_ph("bp_hold_d", 400);
    end
    tready = 1'b1;
    cyc(); chk_ph("bp_after", 600);
    chk("bp_beats", beat_count, 32'd7);

    // Stop under backpressure: DRAIN holds the beat, ignores enable and phase_clr
    tready = 1'b0; enable = 1'b0;
    cyc();
    chk("drain_state", 32'(dbg_state), 32'(phase_gen_pkg::ST_DRAIN));
    chk("drain_v", {31'b0, tvalid}, 32'd1);
    chk_ph("drain_d", 600);
    enable = 1'b1; phase_clr = 1'b1;
    cyc();
    chk("drain_state2", 32'(dbg_state), 32'(phase_gen_pkg::ST_DRAIN));
    chk_ph("drain_d2", 600);
    enable = 1'b0; phase_clr = 1'b0; tready = 1'b1;
    cyc();
    chk("drain_done_v", {31'b0, tvalid}, 32'd0);
    chk("drain_done_st", 32'(dbg_state), 32'(phase_gen_pkg::ST_IDLE));
    chk("drain_beats", beat_count, 32'd8);
    enable = 1'b1;
    cyc(); chk_ph("resume", 800);
    enable = 1'b0;
    cyc(); chk_ph("resume_stop", 1000);

    // Wrap with step 3000 from 0
    phase_clr = 1'b1; inc_load = 1'b1; phase_inc = 16'd3000;
    cyc(); phase_clr = 1'b0; inc_load = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk_ph("wrap_ramp", k * 3000);
      chk("wrap_ramp_p", {31'b0, wrap_pulse}, 32'd0);
    end
    cyc(); chk_ph("wrap_beat10", -24472); chk("wrap_pulse", {31'b0, wrap_pulse}, 32'd1);
    cyc(); chk_ph("wrap_beat11", -21472); chk("wrap_pulse_end", {31'b0, wrap_pulse}, 32'd0);
    enable = 1'b0;
    cyc(); chk_ph("wrap_stop", -18472);
    chk("wrap_beats", beat_count, 32'd20);

    // Clamp and bypass: load 40000 on the accept at phase 0
    phase_clr = 1'b1; inc_load = 1'b1; phase_inc = 16'd200;
    cyc(); phase_clr = 1'b0; inc_load = 1'b0;
    enable = 1'b1;
    cyc(); chk_ph("byp_0", 0);
    inc_load = 1'b1; phase_inc = 16'd40000;
    cyc(); inc_load = 1'b0;
    chk_ph("byp_clamp", 25736); chk("byp_nowrap", {31'b0, wrap_pulse}, 32'd0);
    cyc(); chk_ph("byp_fold", 0); chk("byp_wrap", {31'b0, wrap_pulse}, 32'd1);
    chk("byp_beats", beat_count, 32'd22);
    cyc(); chk_ph("byp_next", 25736);
    inc_load = 1'b1; phase_inc = 16'd0;
    cyc(); inc_load = 1'b0; chk_ph("zero_inc0", 25736);
    cyc(); chk_ph("zero_inc1", 25736);

    // Reset mid-stream at 1200
    enable = 1'b0;
    cyc();
    phase_clr = 1'b1; inc_load = 1'b1; phase_inc = 16'd200;
    cyc(); phase_clr = 1'b0; inc_load = 1'b0;
    enable = 1'b1;
    cyc(); chk_ph("pre_rst_0", 0);
    for (int i = 0; i < 6; i++) cyc();
    chk_ph("pre_rst_1200", 1200);
    #2 aresetn = 1'b0; enable = 1'b0;
    #1;
    chk("async_tvalid", {31'b0, tvalid}, 32'd0);
    chk("async_tdata", {16'b0, tdata}, 32'd0);
    chk("async_beats", beat_count, 32'd0);
    cyc(); aresetn = 1'b1;
    cyc(); cyc();
    chk("post_rst_idle", {31'b0, tvalid}, 32'd0);
    enable = 1'b1;
    cyc(); chk("restart_v", {31'b0, tvalid}, 32'd1); chk_ph("restart_0", 0);
    cyc(); chk("restart_beats", beat_count, 32'd1);
    enable = 1'b0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
